uart_axi_lite_regif: RTL and testbench
======================================

// Module: uart_axi_lite_regif
// PURPOSE
// - AXI4-Lite slave register interface for a 16550-compatible UART.
// - Decodes the 8-entry 16550 register map and holds the control registers (IER/FCR/LCR/MCR/SPR/DLL/DLM), the THR and a one-byte RHR.
// - Exports the registers to the TX/RX/baud datapath.
// - Generates the prioritised interrupt, reported on irq/irq_n and in the ISR.
// PARAMETERS
// - DL_WIDTH    16  divisor latch width, {DLM,DLL}
// - PSD_WIDTH   4   prescaler-divisor field width carried in regs_out
// - FIFO_DEPTH  16  TX/RX FIFO depth; sizes FCR trigger interpretation, passed to datapath
// PORTS
// - clk          in   1   system clock
// - rst          in   1   asynchronous, active-low reset
// - awaddr       in   axi_lite_addr_t  write address; register index = awaddr[2:0]
// - awvalid/awready in/out 1  AW handshake
// - wdata        in   axi_lite_data_t  write data; only [7:0] used
// - wstrb        in   axi_lite_strb_t  write happens only if wstrb[0]
// - wvalid/wready in/out 1  W handshake
// - bvalid/bready out/in 1  B handshake
// - bresp        out  axi_lite_resp_t  always OKAY
// - araddr       in   axi_lite_addr_t  read address; index = araddr[2:0]
// - arvalid/arready in/out 1  AR handshake
// - rdata        out  axi_lite_data_t  {24'b0, reg byte}
// - rvalid/rready out/in 1  R handshake
// - rresp        out  axi_lite_resp_t  always OKAY
// - regs_out     out  uart_16550_regs_t  current register file to datapath
// - wr_en        out  1  THR-written pulse (push to TX FIFO)
// - rd_en        out  1  pop request to RX FIFO
// - rd_data      in   8  RX FIFO head byte
// - tx_ready     in   1  TX holding/FIFO empty (THRE)
// - rx_ready     in   1  RX FIFO has data
// - parity_err / framing_err / overrun_err  in  1  level line-status errors
// - new_baud     out  1  pulse: DLL or DLM written
// - irq          out  1  interrupt, active high
// - irq_n        out  1  ~irq
// BEHAVIOUR
// Reset values:
// - IER=0, FCR=0, LCR=8'h03, MCR=0, SPR=0, DLL=8'h01, DLM=0, THR=0, RHR=0, rhr_has_data=0.
// - bvalid=rvalid=0, rdata=0, wr_en=new_baud=0, awready=wready=arready=1.
// Write channel:
// - awready=wready=1 while no B pending.
// - Accept only when awvalid&wvalid both high (same edge).
// - At the accept edge: bvalid<=1 (bresp OKAY), held until bready; wr_en/new_baud<=1 for exactly that first bvalid cycle.
// Read channel:
// - arready=1 while no R pending.
// - At the accept edge: rdata<=selected byte, rvalid<=1 (rresp OKAY), held until rready.
// - Read and write channels are independent and may be accepted in the same cycle.
// Register map (DLAB=LCR[7]):
// - 0: R=RHR, W=THR (wr_en) | DLAB: DLL (new_baud)
// - 1: IER | DLAB: DLM (new_baud)
// - 2: R=ISR, W=FCR
// - 3: LCR
// - 4: MCR
// - 5: LSR (RO) = {1'b0, tx_ready, tx_ready, 1'b0, framing_err, parity_err, overrun_err, rhr_has_data}
// - 6: MSR (RO) = 0
// - 7: SPR
// - Writes to RO addresses are ignored.
// RHR:
// - Internal flag named exactly rhr_has_data; benches deposit it hierarchically.
// - rhr_has_data is written only on load/clear events, never refreshed every cycle.
// - rd_en = rx_ready & ~rhr_has_data (combinational).
// - While rd_en: RHR<=rd_data, rhr_has_data<=1 at the clock edge.
// - Accepted read of addr 0 with DLAB=0 clears rhr_has_data. rd_en cannot fire while RHR is full, so load and clear never collide.
// - Reading an empty RHR returns the stale byte, no error.
// Interrupts (level, combinational from state):
// - LS = IER[2] & (parity_err | framing_err | overrun_err)
// - RX = IER[0] & rhr_has_data
// - TX = IER[1] & tx_ready
// - Priority LS > RX > TX.
// - ISR[7:5]=0. ISR[4:0]: LS=5'b01100, RX=5'b01000, TX=5'b00100, none=5'b00011.
// - irq = LS|RX|TX; irq_n = ~irq. irq=0 after reset (IER=0).
// Async reset mid-transaction: abandons the pending B/R response and restores all reset values.
// STRUCTURE
// - axi4_lite_pkg: axi_lite_addr_t/data_t/strb_t/resp_t, RESP_OKAY.
// - uart_16550_regs_pkg: uart_16550_regs_t, register index constants, ISR codes, reset constants.
// - Optional sub-module uart_irq_ctrl: priority encoder producing the ISR code and irq.
// TESTING
// - Reset, read LCR/DLAB-DLL -> 8'h03, 8'h01; write IER=07, LCR=03; deposit rhr_has_data=1 -> irq=1; read RHR -> irq_n=1 next cycle.
// - LCR=83; write/read addr0=AA, addr1=55 -> read back AA, 55; new_baud high during bvalid cycle of DLL write.
// - LCR=03; write addr0=AB -> wr_en high during bvalid cycle, regs_out THR=AB, no new_baud.
// - rx_ready=1, rd_data=AB -> rd_en=1, RHR loads AB; read addr0 -> AB, rd_en reasserts while rx_ready.
// - IER=07, parity_err=1 -> ISR[4:0]=01100; parity_err=0 with rhr_has_data=1 -> 01000; clear RHR, tx_ready=1 -> 00100; tx_ready=0 -> 00011.
// - Reset asserted with bvalid pending -> bvalid=0, registers back to reset values.

Source files
------------

// File: rtl/axi4_lite_pkg.sv
// AXI4-Lite channel types shared by the UART register interface.
package axi4_lite_pkg;
  typedef logic [31:0] axi_lite_addr_t;
  typedef logic [31:0] axi_lite_data_t;
  typedef logic [3:0]  axi_lite_strb_t;
  typedef logic [1:0]  axi_lite_resp_t;

  localparam axi_lite_resp_t RESP_OKAY = 2'b00;
endpackage

// File: rtl/uart_16550_regs_pkg.sv
// 16550 register map: indices, ISR codes, reset values and the register bundle
// exported to the TX/RX/baud datapath.
package uart_16550_regs_pkg;
  localparam int UART_DL_W  = 16;
  localparam int UART_PSD_W = 4;

  typedef logic [2:0] uart_reg_idx_t;

  localparam uart_reg_idx_t REG_RHR_THR = 3'd0;
  localparam uart_reg_idx_t REG_IER     = 3'd1;
  localparam uart_reg_idx_t REG_ISR_FCR = 3'd2;
  localparam uart_reg_idx_t REG_LCR     = 3'd3;
  localparam uart_reg_idx_t REG_MCR     = 3'd4;
  localparam uart_reg_idx_t REG_LSR     = 3'd5;
  localparam uart_reg_idx_t REG_MSR     = 3'd6;
  localparam uart_reg_idx_t REG_SPR     = 3'd7;

  localparam logic [4:0] ISR_LS   = 5'b01100;
  localparam logic [4:0] ISR_RX   = 5'b01000;
  localparam logic [4:0] ISR_TX   = 5'b00100;
  localparam logic [4:0] ISR_NONE = 5'b00011;

  localparam logic [7:0] IER_RST = 8'h00;
  localparam logic [7:0] FCR_RST = 8'h00;
  localparam logic [7:0] LCR_RST = 8'h03;
  localparam logic [7:0] MCR_RST = 8'h00;
  localparam logic [7:0] SPR_RST = 8'h00;
  localparam logic [7:0] DLL_RST = 8'h01;
  localparam logic [7:0] DLM_RST = 8'h00;
  localparam logic [7:0] THR_RST = 8'h00;
  localparam logic [7:0] RHR_RST = 8'h00;

  typedef struct packed {
    logic [7:0]            ier;
    logic [7:0]            fcr;
    logic [7:0]            lcr;
    logic [7:0]            mcr;
    logic [7:0]            spr;
    logic [7:0]            dll;
    logic [7:0]            dlm;
    logic [7:0]            thr;
    logic [7:0]            rhr;
    logic [UART_DL_W-1:0]  dl;
    logic [UART_PSD_W-1:0] psd;
    logic [7:0]            rx_trig;
  } uart_16550_regs_t;

  // FCR[7:6] trigger level scaled to the actual FIFO depth.
  function automatic logic [7:0] fcr_rx_trigger(input logic [1:0] sel, input int depth);
    case (sel)
      2'd0:    return 8'd1;
      2'd1:    return 8'(depth / 4);
      2'd2:    return 8'(depth / 2);
      default: return 8'(depth - 2);
    endcase
  endfunction
endpackage

// File: rtl/uart_axi_lite_regif_irq_ctrl.sv
// Prioritised 16550 interrupt encoder: line status > RX data > TX empty.
module uart_irq_ctrl
  import uart_16550_regs_pkg::*;
(
  input  logic [2:0] i_ier,
  input  logic       i_rhr_has_data,
  input  logic       i_tx_ready,
  input  logic       i_parity_err,
  input  logic       i_framing_err,
  input  logic       i_overrun_err,
  output logic [7:0] o_isr,
  output logic       o_irq
);
  logic w_ls, w_rx, w_tx;

  assign w_ls = i_ier[2] & (i_parity_err | i_framing_err | i_overrun_err);
  assign w_rx = i_ier[0] & i_rhr_has_data;
  assign w_tx = i_ier[1] & i_tx_ready;

  always_comb begin
    o_isr = {3'b000, ISR_NONE};
    o_irq = 1'b1;
    if (w_ls)      o_isr = {3'b000, ISR_LS};
    else if (w_rx) o_isr = {3'b000, ISR_RX};
    else if (w_tx) o_isr = {3'b000, ISR_TX};
    else           o_irq = 1'b0;
  end
endmodule

// File: rtl/uart_axi_lite_regif.sv
// AXI4-Lite slave exposing the 16550 register map; holds the control registers,
// THR and a one-byte RHR, and drives the datapath and interrupt outputs.
module uart_axi_lite_regif
  import axi4_lite_pkg::*;
  import uart_16550_regs_pkg::*;
#(
  parameter int DL_WIDTH   = 16,
  parameter int PSD_WIDTH  = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  axi_lite_addr_t   awaddr,
  input  logic             awvalid,
  output logic             awready,
  input  axi_lite_data_t   wdata,
  input  axi_lite_strb_t   wstrb,
  input  logic             wvalid,
  output logic             wready,
  output logic             bvalid,
  input  logic             bready,
  output axi_lite_resp_t   bresp,
  input  axi_lite_addr_t   araddr,
  input  logic             arvalid,
  output logic             arready,
  output axi_lite_data_t   rdata,
  output logic             rvalid,
  input  logic             rready,
  output axi_lite_resp_t   rresp,
  output uart_16550_regs_t regs_out,
  output logic             wr_en,
  output logic             rd_en,
  input  logic [7:0]       rd_data,
  input  logic             tx_ready,
  input  logic             rx_ready,
  input  logic             parity_err,
  input  logic             framing_err,
  input  logic             overrun_err,
  output logic             new_baud,
  output logic             irq,
  output logic             irq_n
);
  logic           r_bvalid, r_rvalid, r_wr_en, r_new_baud;
  axi_lite_data_t r_rdata;
  logic [7:0]     r_ier, r_fcr, r_lcr, r_mcr, r_spr, r_dll, r_dlm, r_thr, r_rhr;
  logic           rhr_has_data;

  logic                 w_dlab, w_wr_acc, w_wr_do, w_rd_acc, w_irq;
  uart_reg_idx_t        w_widx, w_ridx;
  logic [7:0]           w_rbyte, w_isr, w_lsr;
  logic [DL_WIDTH-1:0]  w_dl;
  logic [PSD_WIDTH-1:0] w_psd;
  logic                 w_unused;

  assign w_dlab   = r_lcr[7];
  assign w_widx   = awaddr[2:0];
  assign w_ridx   = araddr[2:0];
  assign w_wr_acc = awvalid & wvalid & ~r_bvalid;
  assign w_wr_do  = w_wr_acc & wstrb[0];
  assign w_rd_acc = arvalid & ~r_rvalid;
  assign w_lsr    = {1'b0, tx_ready, tx_ready, 1'b0, framing_err, parity_err, overrun_err,
                     rhr_has_data};
  assign w_unused = ^{awaddr[31:3], wdata[31:8], wstrb[3:1], araddr[31:3]};

  assign awready = ~r_bvalid;
  assign wready  = ~r_bvalid;
  assign arready = ~r_rvalid;
  assign bvalid  = r_bvalid;
  assign rvalid  = r_rvalid;
  assign bresp   = RESP_OKAY;
  assign rresp   = RESP_OKAY;
  assign rdata   = r_rdata;
  assign wr_en   = r_wr_en;
  assign new_baud = r_new_baud;
  assign rd_en   = rx_ready & ~rhr_has_data;
  assign irq     = w_irq;
  assign irq_n   = ~w_irq;

  uart_irq_ctrl u_irq_ctrl (
    .i_ier          (r_ier[2:0]),
    .i_rhr_has_data (rhr_has_data),
    .i_tx_ready     (tx_ready),
    .i_parity_err   (parity_err),
    .i_framing_err  (framing_err),
    .i_overrun_err  (overrun_err),
    .o_isr          (w_isr),
    .o_irq          (w_irq)
  );

  always_comb begin
    case (w_ridx)
      REG_RHR_THR: w_rbyte = w_dlab ? r_dll : r_rhr;
      REG_IER:     w_rbyte = w_dlab ? r_dlm : r_ier;
      REG_ISR_FCR: w_rbyte = w_isr;
      REG_LCR:     w_rbyte = r_lcr;
      REG_MCR:     w_rbyte = r_mcr;
      REG_LSR:     w_rbyte = w_lsr;
      REG_MSR:     w_rbyte = 8'h00;
      default:     w_rbyte = r_spr;
    endcase
  end

  // Handshake state; wr_en/new_baud are one-cycle pulses aligned to the first bvalid cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bvalid   <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rdata    <= '0;
      r_wr_en    <= 1'b0;
      r_new_baud <= 1'b0;
    end else begin
      r_wr_en    <= w_wr_do & (w_widx == REG_RHR_THR) & ~w_dlab;
      r_new_baud <= w_wr_do & ((w_widx == REG_RHR_THR) | (w_widx == REG_IER)) & w_dlab;
      if (w_wr_acc)                r_bvalid <= 1'b1;
      else if (r_bvalid && bready) r_bvalid <= 1'b0;
      if (w_rd_acc) begin
        r_rvalid <= 1'b1;
        r_rdata  <= {24'h000000, w_rbyte};
      end else if (r_rvalid && rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ier <= IER_RST;
      r_fcr <= FCR_RST;
      r_lcr <= LCR_RST;
      r_mcr <= MCR_RST;
      r_spr <= SPR_RST;
      r_dll <= DLL_RST;
      r_dlm <= DLM_RST;
      r_thr <= THR_RST;
    end else if (w_wr_do) begin
      case (w_widx)
        REG_RHR_THR: if (w_dlab) r_dll <= wdata[7:0]; else r_thr <= wdata[7:0];
        REG_IER:     if (w_dlab) r_dlm <= wdata[7:0]; else r_ier <= wdata[7:0];
        REG_ISR_FCR: r_fcr <= wdata[7:0];
        REG_LCR:     r_lcr <= wdata[7:0];
        REG_MCR:     r_mcr <= wdata[7:0];
        REG_SPR:     r_spr <= wdata[7:0];
        default:     ;
      endcase
    end
  end

  // Load and clear cannot collide: rd_en only fires while the RHR is empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rhr        <= RHR_RST;
      rhr_has_data <= 1'b0;
    end else if (rd_en) begin
      r_rhr        <= rd_data;
      rhr_has_data <= 1'b1;
    end else if (w_rd_acc && (w_ridx == REG_RHR_THR) && !w_dlab) begin
      rhr_has_data <= 1'b0;
    end
  end

  assign w_dl  = DL_WIDTH'({r_dlm, r_dll});
  assign w_psd = '0;

  always_comb begin
    regs_out         = '0;
    regs_out.ier     = r_ier;
    regs_out.fcr     = r_fcr;
    regs_out.lcr     = r_lcr;
    regs_out.mcr     = r_mcr;
    regs_out.spr     = r_spr;
    regs_out.dll     = r_dll;
    regs_out.dlm     = r_dlm;
    regs_out.thr     = r_thr;
    regs_out.rhr     = r_rhr;
    regs_out.dl      = UART_DL_W'(w_dl);
    regs_out.psd     = UART_PSD_W'(w_psd);
    regs_out.rx_trig = fcr_rx_trigger(r_fcr[7:6], FIFO_DEPTH);
  end
endmodule

// File: tb/tb_uart_axi_lite_regif.sv
// Directed bench for the 16550 AXI4-Lite register interface with a B/R scoreboard.
module tb_uart_axi_lite_regif;
  import axi4_lite_pkg::*;
  import uart_16550_regs_pkg::*;

  logic clk, rst;
  axi_lite_addr_t awaddr, araddr;
  axi_lite_data_t wdata, rdata;
  axi_lite_strb_t wstrb;
  axi_lite_resp_t bresp, rresp;
  logic awvalid, awready, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rvalid, rready;
  uart_16550_regs_t regs_out;
  logic wr_en, rd_en, tx_ready, rx_ready, new_baud, irq, irq_n;
  logic parity_err, framing_err, overrun_err;
  logic [7:0] rd_data;

  int errors = 0;
  int checks = 0;

  typedef struct { bit wr_en; bit nb; } bexp_t;
  bexp_t bq[$];
  logic [7:0] rq[$];

  uart_axi_lite_regif dut (
    .clk(clk), .rst(rst),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rready(rready), .rresp(rresp),
    .regs_out(regs_out), .wr_en(wr_en), .rd_en(rd_en), .rd_data(rd_data),
    .tx_ready(tx_ready), .rx_ready(rx_ready),
    .parity_err(parity_err), .framing_err(framing_err), .overrun_err(overrun_err),
    .new_baud(new_baud), .irq(irq), .irq_n(irq_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Response monitor: B and R are compared against queued expectations.
  always @(negedge clk) begin : mon
    bexp_t      be;
    logic [7:0] re;
    if (bvalid) begin
      checks++;
      if (bq.size() == 0) begin
        errors++;
        $display("FAIL b_unexpected: bvalid with empty queue");
      end else begin
        be = bq.pop_front();
        if (wr_en !== be.wr_en || new_baud !== be.nb || bresp !== RESP_OKAY) begin
          errors++;
          $display("FAIL b_resp: wr_en=%0b new_baud=%0b bresp=%0h expected wr_en=%0b new_baud=%0b bresp=0",
                   wr_en, new_baud, bresp, be.wr_en, be.nb);
        end
      end
    end
    if (rvalid) begin
      checks++;
      if (rq.size() == 0) begin
        errors++;
        $display("FAIL r_unexpected: rvalid with empty queue, rdata=%0h", rdata);
      end else begin
        re = rq.pop_front();
        if (rdata !== {24'h0, re} || rresp !== RESP_OKAY) begin
          errors++;
          $display("FAIL r_data: got %0h resp %0h expected %0h resp 0", rdata, rresp, re);
        end
      end
    end
  end

  task automatic axi_write(input logic [2:0] a, input logic [7:0] d, input logic [3:0] s,
                           input bit ew, input bit en, input bit push);
    int n;
    n = 0;
    @(negedge clk);
    while (!(awready && wready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!(awready && wready)) begin
      checks++;
      errors++;
      $display("FAIL aw_timeout: awready=%0b expected 1", awready);
    end
    awaddr  = {29'd0, a};
    wdata   = {24'd0, d};
    wstrb   = s;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    if (push) bq.push_back('{ew, en});
    @(posedge clk);
    #1;
    awvalid = 1'b0;
    wvalid  = 1'b0;
  endtask

  task automatic axi_read(input logic [2:0] a, input logic [7:0] exp);
    int n;
    n = 0;
    @(negedge clk);
    while (!arready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!arready) begin
      checks++;
      errors++;
      $display("FAIL ar_timeout: arready=%0b expected 1", arready);
    end
    araddr  = {29'd0, a};
    arvalid = 1'b1;
    rq.push_back(exp);
    @(posedge clk);
    #1;
    arvalid = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    awaddr = '0; wdata = '0; wstrb = '0; awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    araddr = '0; arvalid = 1'b0; rready = 1'b1;
    rd_data = 8'h00; tx_ready = 1'b0; rx_ready = 1'b0;
    parity_err = 1'b0; framing_err = 1'b0; overrun_err = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {29'd0, awready, wready, arready}, 32'h7);
    chk("rst_valid", {30'd0, bvalid, rvalid}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_pulses", {30'd0, wr_en, new_baud}, 32'h0);
    chk("rst_irq", {30'd0, irq, irq_n}, 32'h1);
    chk("rst_lcr_dll", {16'd0, regs_out.lcr, regs_out.dll}, 32'h0301);
    rst = 1'b1;

    // Reset values through the bus and the RX interrupt path
    axi_read(3'd3, 8'h03);
    axi_write(3'd3, 8'h83, 4'h1, 1'b0, 1'b0, 1'b1);
    axi_read(3'd0, 8'h01);
    axi_write(3'd1, 8'h07, 4'h1, 1'b0, 1'b1, 1'b1);
    axi_write(3'd3, 8'h03, 4'h1, 1'b0, 1'b0, 1'b1);
    axi_write(3'd1, 8'h07, 4'h1, 1'b0, 1'b0, 1'b1);
    chk("ier_07", {24'd0, regs_out.ier}, 32'h07);
    @(negedge clk);
    dut.rhr_has_data = 1'b1;
    #1;
    chk("irq_rx", {31'd0, irq}, 32'h1);
    axi_read(3'd0, 8'h00);
    chk("irq_n_after_rhr_read", {31'd0, irq_n}, 32'h1);

    // Divisor latch access
    axi_write(3'd3, 8'h83, 4'h1, 1'b0, 1'b0, 1'b1);
    axi_write(3'd0, 8'hAA, 4'h1, 1'b0, 1'b1, 1'b1);
    axi_write(3'd1, 8'h55, 4'h1, 1'b0, 1'b1, 1'b1);
    axi_read(3'd0, 8'hAA);
    axi_read(3'd1, 8'h55);
    chk("dl_value", {16'd0, regs_out.dl}, 32'h55AA);
    axi_write(3'd3, 8'h03, 4'h1, 1'b0, 1'b0, 1'b1);

    // THR write
    axi_write(3'd0, 8'hAB, 4'h1, 1'b1, 1'b0, 1'b1);
    chk("thr_ab", {24'd0, regs_out.thr}, 32'hAB);

    // Strobe-less write and RO-address write are ignored
    axi_write(3'd3, 8'h83, 4'h0, 1'b0, 1'b0, 1'b1);
    axi_read(3'd3, 8'h03);
    axi_write(3'd5, 8'hFF, 4'h1, 1'b0, 1'b0, 1'b1);
    axi_read(3'd5, 8'h00);
    axi_read(3'd6, 8'h00);

    // RX FIFO pop into RHR
    @(negedge clk);
    rd_data = 8'hAB;
    rx_ready = 1'b1;
    #1;
    chk("rd_en_empty", {31'd0, rd_en}, 32'h1);
    @(posedge clk);
    #1;
    chk("rd_en_full", {31'd0, rd_en}, 32'h0);
    chk("rhr_ab", {24'd0, regs_out.rhr}, 32'hAB);
    axi_read(3'd0, 8'hAB);
    chk("rd_en_reassert", {31'd0, rd_en}, 32'h1);
    rx_ready = 1'b0;
    rd_data = 8'h00;

    // Interrupt priority
    @(negedge clk);
    parity_err = 1'b1;
    axi_read(3'd2, 8'h0C);
    chk("irq_ls", {31'd0, irq}, 32'h1);
    @(negedge clk);
    parity_err = 1'b0;
    dut.rhr_has_data = 1'b1;
    axi_read(3'd2, 8'h08);
    axi_read(3'd0, 8'hAB);
    @(negedge clk);
    tx_ready = 1'b1;
    axi_read(3'd2, 8'h04);
    axi_read(3'd5, 8'h60);
    @(negedge clk);
    tx_ready = 1'b0;
    framing_err = 1'b1;
    overrun_err = 1'b1;
    axi_read(3'd5, 8'h0A);
    @(negedge clk);
    framing_err = 1'b0;
    overrun_err = 1'b0;
    axi_read(3'd2, 8'h03);
    chk("irq_none", {30'd0, irq, irq_n}, 32'h1);

    // Reset while a B response is pending
    axi_write(3'd7, 8'h5A, 4'h1, 1'b0, 1'b0, 1'b0);
    chk("b_pending", {31'd0, bvalid}, 32'h1);
    chk("spr_5a", {24'd0, regs_out.spr}, 32'h5A);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_b_abandoned", {31'd0, bvalid}, 32'h0);
    chk("rst_regs", {regs_out.spr, regs_out.ier, regs_out.lcr, regs_out.dll}, 32'h00000301);
    chk("rst_thr_rhr", {16'd0, regs_out.thr, regs_out.rhr}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    axi_read(3'd7, 8'h00);

    for (int i = 0; i < 20 && (bq.size() != 0 || rq.size() != 0); i++) @(negedge clk);
    @(negedge clk);
    if (bq.size() != 0 || rq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: b left %0d r left %0d expected 0", bq.size(), rq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
